reset_sequencer: RTL and testbench

Staged reset-release controller for the fabric clock domain. It sits downstream of the stretched power-on reset and owns the per-subsystem resets, for example MAC/PHY, parser, book builder and output stage. It releases the subsystems one at a time, in index order. Before releasing the next stage it waits for the current stage's ready indication, retries on timeout, and latches a sticky fault when retries are exhausted.

---
 rtl/reset_sequencer.sv | 166 ++++++++++++++++
 tb/tb_reset_sequencer.sv | 383 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reset_sequencer.sv
// rtl/reset_sequencer.sv - staged per-subsystem reset release with ready handshake, retry and sticky fault
module reset_sequencer #(
  parameter int NUM_STAGES     = 4,
  parameter int GAP_CYCLES     = 16,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int MAX_RETRIES    = 2,
  localparam int IW = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  soft_rst_req,
  input  logic [NUM_STAGES-1:0] stage_ready,
  output logic [NUM_STAGES-1:0] stage_rst,
  output logic                  all_up,
  output logic                  fault,
  output logic [IW-1:0]         fault_stage
);

  localparam int RW   = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
  localparam int TMAX = (GAP_CYCLES > TIMEOUT_CYCLES) ? GAP_CYCLES : TIMEOUT_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);

  localparam logic [TW-1:0] GAP_LAST     = TW'(GAP_CYCLES - 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [IW-1:0] LAST_IDX     = IW'(NUM_STAGES - 1);
  localparam logic [RW-1:0] RETRY_LIMIT  = RW'(MAX_RETRIES);

  typedef enum logic [2:0] {
    S_HOLD,
    S_RELEASE,
    S_WAIT_READY,
    S_GAP,
    S_UP,
    S_FAULT
  } state_t;

  state_t                state_q, state_d;
  logic [NUM_STAGES-1:0] stage_rst_q, stage_rst_d;
  logic                  all_up_q, all_up_d;
  logic                  fault_q, fault_d;
  logic [IW-1:0]         fault_stage_q, fault_stage_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [TW-1:0]         tmr_q, tmr_d;
  logic [RW-1:0]         retries_q, retries_d;
  logic                  ready_lost;
  logic                  loss_state;

  // A stage below idx (or any stage once up) dropping ready restarts the whole sequence.
  always_comb begin
    ready_lost = 1'b0;
    for (int j = 0; j < NUM_STAGES; j++) begin
      if (!stage_ready[j] && (state_q == S_UP || j < int'(idx_q))) begin
        ready_lost = 1'b1;
      end
    end
  end

  assign loss_state = (state_q == S_GAP) || (state_q == S_RELEASE) ||
                      (state_q == S_WAIT_READY) || (state_q == S_UP);

  always_comb begin
    state_d       = state_q;
    stage_rst_d   = stage_rst_q;
    all_up_d      = all_up_q;
    fault_d       = fault_q;
    fault_stage_d = fault_stage_q;
    idx_d         = idx_q;
    tmr_d         = tmr_q;
    retries_d     = retries_q;

    if (soft_rst_req) begin
      state_d     = S_HOLD;
      stage_rst_d = '1;
      all_up_d    = 1'b0;
      fault_d     = 1'b0;
      idx_d       = '0;
      tmr_d       = '0;
      retries_d   = '0;
    end else if (ready_lost && loss_state) begin
      state_d     = S_HOLD;
      stage_rst_d = '1;
      all_up_d    = 1'b0;
      idx_d       = '0;
      tmr_d       = '0;
    end else begin
      case (state_q)
        S_HOLD, S_GAP: begin
          if (tmr_q == GAP_LAST) begin
            state_d = S_RELEASE;
            tmr_d   = '0;
          end else begin
            tmr_d = tmr_q + 1'b1;
          end
        end
        S_RELEASE: begin
          stage_rst_d[idx_q] = 1'b0;
          tmr_d              = '0;
          state_d            = S_WAIT_READY;
        end
        S_WAIT_READY: begin
          if (stage_ready[idx_q]) begin
            if (idx_q == LAST_IDX) begin
              state_d  = S_UP;
              all_up_d = 1'b1;
            end else begin
              idx_d   = idx_q + 1'b1;
              tmr_d   = '0;
              state_d = S_GAP;
            end
          end else if (tmr_q == TIMEOUT_LAST) begin
            stage_rst_d = '1;
            idx_d       = '0;
            tmr_d       = '0;
            if (retries_q < RETRY_LIMIT) begin
              retries_d = retries_q + 1'b1;
              state_d   = S_HOLD;
            end else begin
              state_d       = S_FAULT;
              fault_d       = 1'b1;
              fault_stage_d = idx_q;
            end
          end else begin
            tmr_d = tmr_q + 1'b1;
          end
        end
        S_UP, S_FAULT: begin
        end
        default: begin
          state_d     = S_HOLD;
          stage_rst_d = '1;
          all_up_d    = 1'b0;
          idx_d       = '0;
          tmr_d       = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_HOLD;
      stage_rst_q   <= '1;
      all_up_q      <= 1'b0;
      fault_q       <= 1'b0;
      fault_stage_q <= '0;
      idx_q         <= '0;
      tmr_q         <= '0;
      retries_q     <= '0;
    end else begin
      state_q       <= state_d;
      stage_rst_q   <= stage_rst_d;
      all_up_q      <= all_up_d;
      fault_q       <= fault_d;
      fault_stage_q <= fault_stage_d;
      idx_q         <= idx_d;
      tmr_q         <= tmr_d;
      retries_q     <= retries_d;
    end
  end

  assign stage_rst   = stage_rst_q;
  assign all_up      = all_up_q;
  assign fault       = fault_q;
  assign fault_stage = fault_stage_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// tb/tb_reset_sequencer.sv - directed and randomized checks of reset_sequencer against a timeline model
module tb_reset_sequencer;

  localparam int N    = 3;
  localparam int GAP  = 4;
  localparam int TO   = 16;
  localparam int MAXR = 1;
  localparam int FW   = 2;
  localparam int VW   = N + 2 + FW;

  logic          clk = 1'b0;
  logic          rst;
  logic          soft_rst_req;
  logic [N-1:0]  stage_ready;
  logic [N-1:0]  stage_rst;
  logic          all_up;
  logic          fault;
  logic [FW-1:0] fault_stage;

  reset_sequencer #(
    .NUM_STAGES    (N),
    .GAP_CYCLES    (GAP),
    .TIMEOUT_CYCLES(TO),
    .MAX_RETRIES   (MAXR)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .soft_rst_req(soft_rst_req),
    .stage_ready (stage_ready),
    .stage_rst   (stage_rst),
    .all_up      (all_up),
    .fault       (fault),
    .fault_stage (fault_stage)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Subsystem behaviour: ready rises delay_c cycles after its reset falls.
  int           delay_c [N];
  int           cnt     [N];
  logic [N-1:0] withhold;
  logic [N-1:0] drop;

  // Timeline model: released-stage count plus absolute edge numbers of the next release / wait start.
  int edge_n      = 0;
  int m_nrel      = 0;
  int m_rel_at    = 0;
  int m_wait_from = 0;
  int m_ret       = 0;
  int m_fs        = 0;
  bit m_wait      = 0;
  bit m_up        = 0;
  bit m_flt       = 0;

  task automatic model_step();
    int chk;
    bit lost;
    edge_n++;
    if (rst) begin
      edge_n = 0; m_nrel = 0; m_up = 0; m_flt = 0; m_fs = 0; m_ret = 0; m_wait = 0;
      m_rel_at = GAP + 1;
      return;
    end
    if (soft_rst_req) begin
      m_flt = 0; m_ret = 0; m_up = 0; m_nrel = 0; m_wait = 0;
      m_rel_at = edge_n + GAP + 1;
      return;
    end
    if (m_flt) return;
    chk  = m_wait ? m_nrel - 1 : m_nrel;
    lost = 0;
    for (int j = 0; j < chk; j++) if (!stage_ready[j]) lost = 1;
    if (lost) begin
      m_up = 0; m_nrel = 0; m_wait = 0;
      m_rel_at = edge_n + GAP + 1;
      return;
    end
    if (m_up) return;
    if (m_wait) begin
      if (stage_ready[m_nrel-1]) begin
        m_wait = 0;
        if (m_nrel == N) m_up = 1;
        else m_rel_at = edge_n + GAP + 1;
      end else if (edge_n == m_wait_from + TO) begin
        m_wait = 0;
        if (m_ret < MAXR) begin
          m_ret++;
          m_rel_at = edge_n + GAP + 1;
        end else begin
          m_flt = 1;
          m_fs  = m_nrel - 1;
        end
        m_nrel = 0;
      end
    end else if (edge_n == m_rel_at) begin
      m_nrel++;
      m_wait      = 1;
      m_wait_from = edge_n;
    end
  endtask

  function automatic logic [VW-1:0] exp_vec();
    logic [N-1:0] r;
    r = '1;
    for (int i = 0; i < m_nrel; i++) r[i] = 1'b0;
    return {r, m_up, m_flt, FW'(m_fs)};
  endfunction

  task automatic drive_env();
    for (int i = 0; i < N; i++) begin
      if (stage_rst[i] !== 1'b0) cnt[i] = 0;
      else cnt[i]++;
      stage_ready[i] = (stage_rst[i] === 1'b0) && !withhold[i] && !drop[i] && (cnt[i] >= delay_c[i]);
    end
  endtask

  task automatic tick();
    drive_env();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic apply_rst();
    rst = 1'b1; soft_rst_req = 1'b0; drop = '0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; soft_rst_req = 1'b0; withhold = '0; drop = '0;
    for (int i = 0; i < N; i++) delay_c[i] = 2;
    tick();
    tick();
    n_cmp++;
    if ({stage_rst, all_up, fault, fault_stage} !== {3'b111, 1'b0, 1'b0, 2'b00}) begin
      n_bad++;
      $display("FAIL reset_values got=%b want=%b", {stage_rst, all_up, fault, fault_stage}, 7'b1110000);
    end
    rst = 1'b0;
  endtask

  task automatic test_clean_bringup();
    int fall_e [N];
    int rdy_e  [N];
    int up_e;
    apply_rst();
    withhold = '0;
    for (int i = 0; i < N; i++) begin delay_c[i] = 2; fall_e[i] = -1; rdy_e[i] = -1; end
    up_e = -1;
    for (int k = 0; k < 200 && up_e < 0; k++) begin
      tick();
      n_cmp++;
      if ({stage_rst, all_up, fault, fault_stage} !== exp_vec()) begin
        n_bad++;
        $display("FAIL clean_cycle edge=%0d got=%b want=%b", edge_n, {stage_rst, all_up, fault, fault_stage}, exp_vec());
      end
      if (edge_n == 5) begin
        n_cmp++;
        if (stage_rst !== 3'b110) begin
          n_bad++;
          $display("FAIL clean_edge5 got=%b want=110", stage_rst);
        end
      end
      for (int i = 0; i < N; i++) begin
        if (fall_e[i] < 0 && stage_rst[i] === 1'b0) fall_e[i] = edge_n;
        if (rdy_e[i] < 0 && stage_ready[i] === 1'b1) rdy_e[i] = edge_n;
      end
      if (all_up === 1'b1) up_e = edge_n;
    end
    for (int i = 1; i < N; i++) begin
      n_cmp++;
      if (rdy_e[i-1] < 0 || fall_e[i] != rdy_e[i-1] + GAP + 1) begin
        n_bad++;
        $display("FAIL clean_release_gap stage=%0d got_edge=%0d want_edge=%0d", i, fall_e[i], rdy_e[i-1] + GAP + 1);
      end
    end
    n_cmp++;
    if (up_e < 0 || up_e != rdy_e[N-1] || fall_e[N-1] != 19) begin
      n_bad++;
      $display("FAIL clean_all_up got_up=%0d got_fall2=%0d want_up=%0d want_fall2=19", up_e, fall_e[N-1], rdy_e[N-1]);
    end
  endtask

  task automatic test_timeout_retry();
    int r;
    bit to_seen, up_seen;
    apply_rst();
    for (int i = 0; i < N; i++) delay_c[i] = 2;
    withhold = 3'b010;
    r = -1; to_seen = 0; up_seen = 0;
    for (int k = 0; k < 300 && !up_seen; k++) begin
      tick();
      n_cmp++;
      if ({stage_rst, all_up, fault, fault_stage} !== exp_vec()) begin
        n_bad++;
        $display("FAIL retry_cycle edge=%0d got=%b want=%b", edge_n, {stage_rst, all_up, fault, fault_stage}, exp_vec());
      end
      if (r < 0 && stage_rst === 3'b100) r = edge_n;
      if (r >= 0 && !to_seen && stage_rst === 3'b111) begin
        to_seen = 1;
        n_cmp++;
        if (edge_n != r + TO || dut.retries_q !== 1'b1) begin
          n_bad++;
          $display("FAIL retry_timeout_edge got_edge=%0d got_retries=%0d want_edge=%0d want_retries=1", edge_n, dut.retries_q, r + TO);
        end
        withhold = '0;
      end
      if (all_up === 1'b1) up_seen = 1;
    end
    n_cmp++;
    if (!to_seen || !up_seen || fault !== 1'b0) begin
      n_bad++;
      $display("FAIL retry_success got_timeout=%0d got_up=%0d got_fault=%b want=1/1/0", to_seen, up_seen, fault);
    end
  endtask

  task automatic test_retries_exhausted();
    apply_rst();
    for (int i = 0; i < N; i++) delay_c[i] = 2;
    withhold = 3'b100;
    for (int k = 0; k < 300 && fault !== 1'b1; k++) begin
      tick();
      n_cmp++;
      if ({stage_rst, all_up, fault, fault_stage} !== exp_vec()) begin
        n_bad++;
        $display("FAIL exhaust_cycle edge=%0d got=%b want=%b", edge_n, {stage_rst, all_up, fault, fault_stage}, exp_vec());
      end
    end
    n_cmp++;
    if ({stage_rst, all_up, fault, fault_stage} !== 7'b1110110) begin
      n_bad++;
      $display("FAIL exhaust_fault got=%b want=1110110", {stage_rst, all_up, fault, fault_stage});
    end
    for (int k = 0; k < 100; k++) begin
      tick();
      n_cmp++;
      if ({stage_rst, all_up, fault, fault_stage} !== 7'b1110110 || exp_vec() !== 7'b1110110) begin
        n_bad++;
        $display("FAIL exhaust_frozen edge=%0d got=%b model=%b want=1110110", edge_n, {stage_rst, all_up, fault, fault_stage}, exp_vec());
      end
    end
  endtask

  task automatic test_soft_in_fault();
    withhold = '0;
    soft_rst_req = 1'b1;
    tick();
    soft_rst_req = 1'b0;
    n_cmp++;
    if ({stage_rst, all_up, fault, fault_stage} !== 7'b1110010) begin
      n_bad++;
      $display("FAIL soft_clear got=%b want=1110010", {stage_rst, all_up, fault, fault_stage});
    end
    for (int k = 1; k <= 5; k++) begin
      tick();
      n_cmp++;
      if ({stage_rst, all_up, fault, fault_stage} !== exp_vec()) begin
        n_bad++;
        $display("FAIL soft_cycle edge=%0d got=%b want=%b", edge_n, {stage_rst, all_up, fault, fault_stage}, exp_vec());
      end
      if (k >= 4) begin
        n_cmp++;
        if (stage_rst[0] !== (k == 4 ? 1'b1 : 1'b0)) begin
          n_bad++;
          $display("FAIL soft_release offset=%0d got=%b want=%b", k, stage_rst[0], (k == 4));
        end
      end
    end
    soft_rst_req = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    soft_rst_req = 1'b0;
    n_cmp++;
    if ({stage_rst, all_up, fault, fault_stage} !== 7'b1110000 || dut.retries_q !== 1'b0 || dut.idx_q !== 2'd0) begin
      n_bad++;
      $display("FAIL soft_and_rst got=%b retries=%0d idx=%0d want=1110000/0/0", {stage_rst, all_up, fault, fault_stage}, dut.retries_q, dut.idx_q);
    end
  endtask

  task automatic test_loss_in_up();
    bit up_seen;
    apply_rst();
    withhold = '0;
    for (int i = 0; i < N; i++) delay_c[i] = $urandom_range(0, 3);
    for (int pass = 0; pass < 2; pass++) begin
      up_seen = 0;
      for (int k = 0; k < 200 && !up_seen; k++) begin
        tick();
        n_cmp++;
        if ({stage_rst, all_up, fault, fault_stage} !== exp_vec()) begin
          n_bad++;
          $display("FAIL loss_cycle pass=%0d edge=%0d got=%b want=%b", pass, edge_n, {stage_rst, all_up, fault, fault_stage}, exp_vec());
        end
        if (all_up === 1'b1) up_seen = 1;
      end
      n_cmp++;
      if (!up_seen || dut.retries_q !== 1'b0) begin
        n_bad++;
        $display("FAIL loss_up pass=%0d got_up=%0d got_retries=%0d want=1/0", pass, up_seen, dut.retries_q);
      end
      if (pass == 0) begin
        drop = 3'b001;
        tick();
        drop = '0;
        n_cmp++;
        if (all_up !== 1'b0 || stage_rst !== 3'b111) begin
          n_bad++;
          $display("FAIL loss_drop got_up=%b got_rst=%b want=0/111", all_up, stage_rst);
        end
      end
    end
  endtask

  task automatic test_ready_vs_timeout();
    apply_rst();
    withhold = '0;
    delay_c[0] = TO; delay_c[1] = 2; delay_c[2] = 2;
    for (int k = 0; k < 21; k++) begin
      tick();
      n_cmp++;
      if ({stage_rst, all_up, fault, fault_stage} !== exp_vec()) begin
        n_bad++;
        $display("FAIL race_cycle edge=%0d got=%b want=%b", edge_n, {stage_rst, all_up, fault, fault_stage}, exp_vec());
      end
    end
    n_cmp++;
    if (dut.idx_q !== 2'd1 || dut.retries_q !== 1'b0 || stage_rst !== 3'b110) begin
      n_bad++;
      $display("FAIL race_ready_wins got_idx=%0d got_retries=%0d got_rst=%b want=1/0/110", dut.idx_q, dut.retries_q, stage_rst);
    end
  endtask

  task automatic test_random();
    apply_rst();
    for (int k = 0; k < 3000; k++) begin
      if (k % 97 == 0) begin
        for (int i = 0; i < N; i++) begin
          delay_c[i]  = $urandom_range(0, 18);
          withhold[i] = ($urandom_range(0, 11) == 0);
        end
      end
      rst          = ($urandom_range(0, 499) == 0);
      soft_rst_req = ($urandom_range(0, 179) == 0);
      drop         = '0;
      if ($urandom_range(0, 59) == 0) drop[$urandom_range(0, N-1)] = 1'b1;
      tick();
      n_cmp++;
      if ({stage_rst, all_up, fault, fault_stage} !== exp_vec()) begin
        n_bad++;
        $display("FAIL random_cycle k=%0d edge=%0d got=%b want=%b", k, edge_n, {stage_rst, all_up, fault, fault_stage}, exp_vec());
      end
    end
    rst = 1'b0; soft_rst_req = 1'b0; drop = '0;
  endtask

  initial begin
    rst = 1'b1; soft_rst_req = 1'b0; stage_ready = '0; withhold = '0; drop = '0;
    for (int i = 0; i < N; i++) begin delay_c[i] = 2; cnt[i] = 0; end
    @(negedge clk);
    test_reset();
    test_clean_bringup();
    test_timeout_retry();
    test_retries_exhausted();
    test_soft_in_fault();
    test_loss_in_up();
    test_ready_vs_timeout();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
